// File: rtl/ball_motion_engine.sv
// ---------------------------------------------------------------------------
// ball_motion_engine
//
// Purpose:
//   Per-frame ball position generator for the pixel renderer. On each
//   frame_start (when not paused) a small FSM steps the x axis, then the y
//   axis, into working registers. It then commits both axes together, so
//   ball_x/ball_y never show a mixed old/new pair. The ball reflects off the
//   edges of the legal centre range [BALL_SIZE, ACTIVE-BALL_SIZE].
//
// Ports:
//   clk          in   1   pixel clock
//   reset        in   1   asynchronous, active-high reset
//   frame_start  in   1   1-cycle frame strobe from the sync generator
//   pause        in   1   level; frame steps are skipped while high
//   speed_x      in   3   pixels per frame, x axis
//   speed_y      in   3   pixels per frame, y axis
//   ball_x       out  10  published centre x
//   ball_y       out  10  published centre y
//   dir_x        out  1   1=right, 0=left
//   dir_y        out  1   1=down, 0=up
//   pos_valid    out  1   high for the single COMMIT cycle; the new pair is
//                         visible on ball_x/ball_y from the following cycle
//   bounce_cnt   out  8   saturating count of axis reflections
//
// Configuration macro:
//   BALL_BOUNCE_CNT_EN  when defined, builds the reflection counter; when
//                       undefined, bounce_cnt is tied to zero.
// ---------------------------------------------------------------------------
module ball_motion_engine #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int BALL_SIZE = 20,
    parameter int INIT_X    = 320,
    parameter int INIT_Y    = 240
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       pause,
    input  logic [2:0] speed_x,
    input  logic [2:0] speed_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       dir_x,
    output logic       dir_y,
    output logic       pos_valid,
    output logic [7:0] bounce_cnt
);

    localparam logic [10:0] X_LO = 11'(BALL_SIZE);
    localparam logic [10:0] X_HI = 11'(H_ACTIVE - BALL_SIZE);
    localparam logic [10:0] Y_LO = 11'(BALL_SIZE);
    localparam logic [10:0] Y_HI = 11'(V_ACTIVE - BALL_SIZE);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STEP_X = 2'd1,
        STEP_Y = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] sx_q, sx_d;
    logic [2:0] sy_q, sy_d;
    logic [9:0] wx_q, wx_d;
    logic [9:0] wy_q, wy_d;
    logic [9:0] ball_x_q, ball_x_d;
    logic [9:0] ball_y_q, ball_y_d;
    logic       dir_x_q, dir_x_d;
    logic       dir_y_q, dir_y_d;

    // {reflected, new_position}
    logic [11:0] step_x_res;
    logic [11:0] step_y_res;

    // One axis step. All compares are on 11-bit values and the bound check is
    // done before any subtraction, so p-s is only formed when p > lo+s.
    function automatic logic [11:0] step_axis(
        input logic [10:0] p,
        input logic [10:0] s,
        input logic [10:0] lo,
        input logic [10:0] hi,
        input logic        dir
    );
        logic [10:0] sum;
        sum = p + s;
        if (dir) begin
            if (sum >= hi) return {1'b1, hi};
            else           return {1'b0, sum};
        end else begin
            if (p <= lo + s) return {1'b1, lo};
            else             return {1'b0, p - s};
        end
    endfunction

`ifdef BALL_BOUNCE_CNT_EN
    // Reflections seen in this frame, held until COMMIT so a reset
    // mid-sequence discards them along with the positions.
    logic [1:0] pend_q, pend_d;
    logic [7:0] bounce_cnt_q, bounce_cnt_d;
    logic [8:0] bounce_sum;
`endif

    always_comb begin
        state_d  = state_q;
        sx_d     = sx_q;
        sy_d     = sy_q;
        wx_d     = wx_q;
        wy_d     = wy_q;
        ball_x_d = ball_x_q;
        ball_y_d = ball_y_q;
        dir_x_d  = dir_x_q;
        dir_y_d  = dir_y_q;
`ifdef BALL_BOUNCE_CNT_EN
        pend_d       = pend_q;
        bounce_cnt_d = bounce_cnt_q;
        bounce_sum   = {1'b0, bounce_cnt_q} + {7'd0, pend_q};
`endif

        step_x_res = step_axis({1'b0, ball_x_q}, {8'd0, sx_q}, X_LO, X_HI, dir_x_q);
        step_y_res = step_axis({1'b0, ball_y_q}, {8'd0, sy_q}, Y_LO, Y_HI, dir_y_q);

        case (state_q)
            IDLE: begin
                if (frame_start && !pause) begin
                    sx_d    = speed_x;
                    sy_d    = speed_y;
                    state_d = STEP_X;
                end
            end
            STEP_X: begin
                wx_d = step_x_res[9:0];
                if (step_x_res[11]) dir_x_d = ~dir_x_q;
`ifdef BALL_BOUNCE_CNT_EN
                pend_d = {1'b0, step_x_res[11]};
`endif
                state_d = STEP_Y;
            end
            STEP_Y: begin
                wy_d = step_y_res[9:0];
                if (step_y_res[11]) dir_y_d = ~dir_y_q;
`ifdef BALL_BOUNCE_CNT_EN
                pend_d = pend_q + {1'b0, step_y_res[11]};
`endif
                state_d = COMMIT;
            end
            COMMIT: begin
                ball_x_d = wx_q;
                ball_y_d = wy_q;
`ifdef BALL_BOUNCE_CNT_EN
                bounce_cnt_d = bounce_sum[8] ? 8'd255 : bounce_sum[7:0];
                pend_d       = 2'd0;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            sx_q     <= 3'd0;
            sy_q     <= 3'd0;
            wx_q     <= 10'(INIT_X);
            wy_q     <= 10'(INIT_Y);
            ball_x_q <= 10'(INIT_X);
            ball_y_q <= 10'(INIT_Y);
            dir_x_q  <= 1'b1;
            dir_y_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            sx_q     <= sx_d;
            sy_q     <= sy_d;
            wx_q     <= wx_d;
            wy_q     <= wy_d;
            ball_x_q <= ball_x_d;
            ball_y_q <= ball_y_d;
            dir_x_q  <= dir_x_d;
            dir_y_q  <= dir_y_d;
        end
    end

`ifdef BALL_BOUNCE_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q       <= 2'd0;
            bounce_cnt_q <= 8'd0;
        end else begin
            pend_q       <= pend_d;
            bounce_cnt_q <= bounce_cnt_d;
        end
    end
    assign bounce_cnt = bounce_cnt_q;
`else
    assign bounce_cnt = 8'd0;
`endif

    assign ball_x    = ball_x_q;
    assign ball_y    = ball_y_q;
    assign dir_x     = dir_x_q;
    assign dir_y     = dir_y_q;
    assign pos_valid = (state_q == COMMIT);

endmodule

// File: tb/tb_ball_motion_engine.sv
// ---------------------------------------------------------------------------
// tb_ball_motion_engine
//
// Directed testbench for ball_motion_engine. Each scenario task drives its
// own stimulus and compares against hand-computed values. The bounce counter
// expectations follow BALL_BOUNCE_CNT_EN.
// ---------------------------------------------------------------------------
module tb_ball_motion_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_start;
    logic       pause;
    logic [2:0] speed_x;
    logic [2:0] speed_y;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       dir_x;
    logic       dir_y;
    logic       pos_valid;
    logic [7:0] bounce_cnt;

    int tests = 0;
    int fails = 0;

`ifdef BALL_BOUNCE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    ball_motion_engine dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .pause       (pause),
        .speed_x     (speed_x),
        .speed_y     (speed_y),
        .ball_x      (ball_x),
        .ball_y      (ball_y),
        .dir_x       (dir_x),
        .dir_y       (dir_y),
        .pos_valid   (pos_valid),
        .bounce_cnt  (bounce_cnt)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // One frame: pulse frame_start, wait (bounded) for pos_valid, then one
    // more cycle so the committed pair is visible.
    task automatic do_frame();
        int waited;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        waited = 0;
        while (!pos_valid && waited < 8) begin
            tick();
            waited++;
        end
        if (!pos_valid) begin
            tests++;
            fails++;
            $display("FAIL frame_timeout: pos_valid=%0b after %0d cycles, required 1", pos_valid, waited);
        end
        tick();
    endtask

    task automatic run_frames(input int n);
        for (int i = 0; i < n; i++) do_frame();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tests++;
        if (ball_x !== 10'd320 || ball_y !== 10'd240) begin
            fails++;
            $display("FAIL reset_pos: got (%0d,%0d) required (320,240)", ball_x, ball_y);
        end
        tests++;
        if (dir_x !== 1'b1 || dir_y !== 1'b1 || pos_valid !== 1'b0 || bounce_cnt !== 8'd0) begin
            fails++;
            $display("FAIL reset_flags: dir=(%0b,%0b) pv=%0b cnt=%0d required (1,1) 0 0",
                     dir_x, dir_y, pos_valid, bounce_cnt);
        end
        reset = 1'b0;
        tick();
        $display("[TB] reset: ball=(%0d,%0d)", ball_x, ball_y);
    endtask

    task automatic test_basic_step();
        logic [3:0] pv_hist;
        speed_x = 3'd2;
        speed_y = 3'd2;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        pv_hist = '0;
        for (int i = 1; i <= 4; i++) begin
            pv_hist[i-1] = pos_valid;
            tick();
        end
        tests++;
        if (pv_hist !== 4'b0100) begin
            fails++;
            $display("FAIL latency: pos_valid history (cycles N+4..N+1)=%b required 0100", pv_hist);
        end
        tests++;
        if (ball_x !== 10'd322 || ball_y !== 10'd242) begin
            fails++;
            $display("FAIL basic_pos: got (%0d,%0d) required (322,242)", ball_x, ball_y);
        end
        tests++;
        if (dir_x !== 1'b1 || dir_y !== 1'b1) begin
            fails++;
            $display("FAIL basic_dir: got (%0b,%0b) required (1,1)", dir_x, dir_y);
        end
        $display("[TB] basic step: ball=(%0d,%0d) pv_hist=%b", ball_x, ball_y, pv_hist);
    endtask

    task automatic test_right_edge();
        apply_reset();
        speed_y = 3'd0;
        speed_x = 3'd7;
        run_frames(42);            // 320 + 294 = 614
        speed_x = 3'd2;
        run_frames(2);             // 618
        tests++;
        if (ball_x !== 10'd618 || dir_x !== 1'b1) begin
            fails++;
            $display("FAIL edge_preload: got x=%0d dir=%0b required 618 1", ball_x, dir_x);
        end
        do_frame();                // 620 >= 620 -> clamp and reflect
        tests++;
        if (ball_x !== 10'd620 || dir_x !== 1'b0) begin
            fails++;
            $display("FAIL edge_reflect: got x=%0d dir=%0b required 620 0", ball_x, dir_x);
        end
        do_frame();
        tests++;
        if (ball_x !== 10'd618 || dir_x !== 1'b0 || ball_y !== 10'd240) begin
            fails++;
            $display("FAIL edge_after: got x=%0d dir=%0b y=%0d required 618 0 240", ball_x, dir_x, ball_y);
        end
        tests++;
        if (bounce_cnt !== (CNT_EN ? 8'd1 : 8'd0)) begin
            fails++;
            $display("FAIL edge_cnt: got %0d required %0d", bounce_cnt, CNT_EN ? 1 : 0);
        end
        $display("[TB] right edge: x=%0d dir_x=%0b cnt=%0d", ball_x, dir_x, bounce_cnt);
    endtask

    task automatic test_corner();
        apply_reset();
        // x: 320 -> reflect at 620 (43 frames), down to 25 (85 frames), 21 at speed 4
        speed_y = 3'd0;
        speed_x = 3'd7;
        run_frames(128);
        speed_x = 3'd4;
        run_frames(1);
        // y: 240 -> reflect at 460 (32 frames), down to 26 (62 frames), 21 at speed 5
        speed_x = 3'd0;
        speed_y = 3'd7;
        run_frames(94);
        speed_y = 3'd5;
        run_frames(1);
        tests++;
        if (ball_x !== 10'd21 || ball_y !== 10'd21 || dir_x !== 1'b0 || dir_y !== 1'b0) begin
            fails++;
            $display("FAIL corner_preload: got (%0d,%0d) dir=(%0b,%0b) required (21,21) (0,0)",
                     ball_x, ball_y, dir_x, dir_y);
        end
        tests++;
        if (bounce_cnt !== (CNT_EN ? 8'd2 : 8'd0)) begin
            fails++;
            $display("FAIL corner_cnt_pre: got %0d required %0d", bounce_cnt, CNT_EN ? 2 : 0);
        end
        speed_x = 3'd3;
        speed_y = 3'd3;
        do_frame();
        tests++;
        if (ball_x !== 10'd20 || ball_y !== 10'd20 || dir_x !== 1'b1 || dir_y !== 1'b1) begin
            fails++;
            $display("FAIL corner_hit: got (%0d,%0d) dir=(%0b,%0b) required (20,20) (1,1)",
                     ball_x, ball_y, dir_x, dir_y);
        end
        tests++;
        if (bounce_cnt !== (CNT_EN ? 8'd4 : 8'd0)) begin
            fails++;
            $display("FAIL corner_cnt: got %0d required %0d", bounce_cnt, CNT_EN ? 4 : 0);
        end
        $display("[TB] corner: ball=(%0d,%0d) dir=(%0b,%0b) cnt=%0d", ball_x, ball_y, dir_x, dir_y, bounce_cnt);
    endtask

    task automatic test_pause();
        int pv_count;
        pv_count = 0;
        pause = 1'b1;
        speed_x = 3'd5;
        speed_y = 3'd5;
        for (int f = 0; f < 5; f++) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            for (int c = 0; c < 4; c++) begin
                if (pos_valid) pv_count++;
                tick();
            end
        end
        pause = 1'b0;
        tests++;
        if (pv_count !== 0) begin
            fails++;
            $display("FAIL pause_valid: got %0d pos_valid pulses required 0", pv_count);
        end
        tests++;
        if (ball_x !== 10'd20 || ball_y !== 10'd20) begin
            fails++;
            $display("FAIL pause_pos: got (%0d,%0d) required (20,20)", ball_x, ball_y);
        end
        $display("[TB] pause: pulses=%0d ball=(%0d,%0d)", pv_count, ball_x, ball_y);
    endtask

    task automatic test_back_to_back();
        int pv_count;
        int pv_cycle;
        pv_count = 0;
        pv_cycle = -1;
        speed_x = 3'd1;
        speed_y = 3'd1;
        frame_start = 1'b1;
        tick();                    // cycle N sampled
        tick();                    // cycle N+1 sampled, must be ignored
        frame_start = 1'b0;
        for (int c = 2; c < 10; c++) begin
            if (pos_valid) begin
                pv_count++;
                pv_cycle = c;
            end
            tick();
        end
        tests++;
        if (pv_count !== 1 || pv_cycle !== 3) begin
            fails++;
            $display("FAIL b2b_valid: got %0d pulses at cycle N+%0d required 1 at N+3", pv_count, pv_cycle);
        end
        tests++;
        if (ball_x !== 10'd21 || ball_y !== 10'd21) begin
            fails++;
            $display("FAIL b2b_pos: got (%0d,%0d) required (21,21)", ball_x, ball_y);
        end
        $display("[TB] back to back: pulses=%0d ball=(%0d,%0d)", pv_count, ball_x, ball_y);
    endtask

    task automatic test_reset_mid();
        int pv_count;
        pv_count = 0;
        speed_x = 3'd6;
        speed_y = 3'd6;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();                    // now in STEP_Y
        reset = 1'b1;
        #1;
        tests++;
        if (ball_x !== 10'd320 || ball_y !== 10'd240 || dir_x !== 1'b1 || dir_y !== 1'b1) begin
            fails++;
            $display("FAIL midreset_state: got (%0d,%0d) dir=(%0b,%0b) required (320,240) (1,1)",
                     ball_x, ball_y, dir_x, dir_y);
        end
        tests++;
        if (pos_valid !== 1'b0 || bounce_cnt !== 8'd0) begin
            fails++;
            $display("FAIL midreset_flags: got pv=%0b cnt=%0d required 0 0", pos_valid, bounce_cnt);
        end
        reset = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            if (pos_valid) pv_count++;
            tick();
        end
        tests++;
        if (pv_count !== 0) begin
            fails++;
            $display("FAIL midreset_valid: got %0d pulses required 0", pv_count);
        end
        speed_x = 3'd2;
        speed_y = 3'd2;
        do_frame();
        tests++;
        if (ball_x !== 10'd322 || ball_y !== 10'd242) begin
            fails++;
            $display("FAIL midreset_next: got (%0d,%0d) required (322,242)", ball_x, ball_y);
        end
        $display("[TB] reset mid-sequence: ball=(%0d,%0d)", ball_x, ball_y);
    endtask

    initial begin
        reset       = 1'b1;
        frame_start = 1'b0;
        pause       = 1'b0;
        speed_x     = 3'd0;
        speed_y     = 3'd0;
        test_reset();
        test_basic_step();
        test_right_edge();
        test_corner();
        test_pause();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
